// File: rtl/data_mem_resp.sv
// data_mem_resp: target side of the data_req/data_gnt/data_r_valid handshake.
// One transaction at a time, programmable grant delay and response latency,
// word-organised single-ported memory with per-byte write enables.
module data_mem_resp #(
  parameter int          DEPTH_LOG2   = 10,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          GNT_DELAY    = 0,
  parameter int          RVALID_DELAY = 1
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        data_req,
  output logic        data_gnt,
  output logic        data_r_valid,
  input  logic        data_write_enable,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_be,
  output logic [31:0] data_rdata,
  output logic        data_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [32:0] RANGE_BYTES = 33'(4) << DEPTH_LOG2;
  localparam logic [3:0] GNT_LOAD = (GNT_DELAY > 0) ? 4'(GNT_DELAY - 1) : 4'd0;
  localparam logic [3:0] LAT_LOAD = (RVALID_DELAY > 1) ? 4'(RVALID_DELAY - 2) : 4'd0;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] GNT_WAIT = 2'd1;
  localparam logic [1:0] LATENCY  = 2'd2;
  localparam logic [1:0] RESP     = 2'd3;

  logic [1:0]            state_reg, state_next;
  logic [3:0]            cnt_reg, cnt_next;
  logic                  gnt;
  logic                  accept;
  logic [31:0]           addr_off;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [31:0]           ram_q;
  logic                  pend_load_reg;
  logic                  pend_err_reg;
  logic [31:0]           held_rdata_reg;
  logic                  held_err_reg;
  logic [31:0]           resp_rdata;
  logic                  unused_bits;

  // Address decode: offset from the base, range check, word index.
  assign addr_off    = data_addr - BASE_ADDR;
  assign in_range    = (data_addr >= BASE_ADDR) && ({1'b0, addr_off} < RANGE_BYTES);
  assign word_idx    = addr_off[DEPTH_LOG2+1:2];
  assign unused_bits = ^{addr_off[1:0], addr_off[31:DEPTH_LOG2+2]};

  assign accept = data_req & gnt;

  // Next-state and grant decision; a request is evaluated in IDLE and RESP.
  always_comb begin
    gnt        = 1'b0;
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE, RESP: begin
        state_next = IDLE;
        if (data_req) begin
          if (GNT_DELAY == 0) begin
            gnt = 1'b1;
          end else begin
            state_next = GNT_WAIT;
            cnt_next   = GNT_LOAD;
          end
        end
      end
      GNT_WAIT: begin
        if (!data_req) begin
          state_next = IDLE;
        end else if (cnt_reg == 4'd0) begin
          gnt = 1'b1;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      LATENCY: begin
        if (cnt_reg == 4'd0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (gnt) begin
      if (RVALID_DELAY == 1) begin
        state_next = RESP;
      end else begin
        state_next = LATENCY;
        cnt_next   = LAT_LOAD;
      end
    end
    // Reset forces the grant low whatever the request does.
    if (RES) begin
      gnt = 1'b0;
    end
  end

  assign data_gnt = gnt;

  // Byte-lane memories: write enabled lanes and capture the read word on the grant edge.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] q_reg;
      // Lane write (in-range stores only) and registered read.
      always_ff @(posedge CLK) begin
        if (accept) begin
          if (data_write_enable && in_range && data_be[gi]) begin
            mem[word_idx] <= data_wdata[8*gi +: 8];
          end
          q_reg <= mem[word_idx];
        end
      end
      assign ram_q[8*gi +: 8] = q_reg;
    end
  endgenerate

  // FSM state, counters, transaction attributes and held response values.
  always_ff @(posedge CLK) begin
    if (RES) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      pend_load_reg  <= 1'b0;
      pend_err_reg   <= 1'b0;
      held_rdata_reg <= 32'd0;
      held_err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == RESP) begin
        held_rdata_reg <= resp_rdata;
        held_err_reg   <= pend_err_reg;
      end
      if (accept) begin
        pend_load_reg <= !data_write_enable && in_range;
        pend_err_reg  <= !in_range;
      end
    end
  end

  // Stores and out-of-range loads respond with zero data.
  assign resp_rdata = pend_load_reg ? ram_q : 32'd0;

  // Response outputs: live during RESP, held afterwards, zero while in reset.
  always_comb begin
    data_r_valid = 1'b0;
    data_rdata   = held_rdata_reg;
    data_err     = held_err_reg;
    if (state_reg == RESP) begin
      data_r_valid = 1'b1;
      data_rdata   = resp_rdata;
      data_err     = pend_err_reg;
    end
    if (RES) begin
      data_r_valid = 1'b0;
      data_rdata   = 32'd0;
      data_err     = 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: three instances cover the default timing,
// long grant/response delays with reset, and request abandonment.
module tb_data_mem_resp;

  logic        clk;
  logic        res;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        req0, req1, req2;
  logic        gnt0, gnt1, gnt2;
  logic        rv0, rv1, rv2;
  logic [31:0] rd0, rd1, rd2;
  logic        err0, err1, err2;

  int checks = 0;
  int errors = 0;

  data_mem_resp u_dut (
    .CLK(clk), .RES(res), .data_req(req0), .data_gnt(gnt0), .data_r_valid(rv0),
    .data_write_enable(we), .data_addr(addr), .data_wdata(wdata), .data_be(be),
    .data_rdata(rd0), .data_err(err0)
  );

  data_mem_resp #(.GNT_DELAY(3), .RVALID_DELAY(4)) u_dly (
    .CLK(clk), .RES(res), .data_req(req1), .data_gnt(gnt1), .data_r_valid(rv1),
    .data_write_enable(we), .data_addr(addr), .data_wdata(wdata), .data_be(be),
    .data_rdata(rd1), .data_err(err1)
  );

  data_mem_resp #(.GNT_DELAY(2), .RVALID_DELAY(1)) u_abn (
    .CLK(clk), .RES(res), .data_req(req2), .data_gnt(gnt2), .data_r_valid(rv2),
    .data_write_enable(we), .data_addr(addr), .data_wdata(wdata), .data_be(be),
    .data_rdata(rd2), .data_err(err2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if it does not match.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // One transaction on the default instance; entered and left 1 time unit after a rising edge.
  task automatic xact0(input string tag, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b,
                       input logic [31:0] exp_rd, input logic exp_err);
    req0 = 1'b1; we = w; addr = a; wdata = d; be = b;
    #1 chk({tag, ".gnt"}, gnt0, 1);
    @(posedge clk); #1;
    req0 = 1'b0; we = 1'b0;
    #1 chk({tag, ".rv"}, rv0, 1);
    chk({tag, ".rd"}, rd0, exp_rd);
    chk({tag, ".err"}, err0, exp_err);
    @(posedge clk); #1;
    chk({tag, ".rv_end"}, rv0, 0);
    chk({tag, ".rd_hold"}, rd0, exp_rd);
  endtask

  // One transaction on the delayed instance: grant on the 4th request cycle, response 4 cycles later.
  task automatic xact1(input string tag, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd);
    req1 = 1'b1; we = w; addr = a; wdata = d; be = 4'hF;
    for (int i = 0; i < 4; i++) begin
      #1 chk({tag, ".gnt"}, gnt1, (i == 3) ? 1 : 0);
      @(posedge clk); #1;
    end
    req1 = 1'b0; we = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1 chk({tag, ".rv"}, rv1, (k == 4) ? 1 : 0);
      if (k == 4) begin
        chk({tag, ".rd"}, rd1, exp_rd);
        chk({tag, ".err"}, err1, 0);
      end
      @(posedge clk); #1;
    end
    chk({tag, ".rv_end"}, rv1, 0);
  endtask

  initial begin
    res = 1'b1; we = 1'b0; addr = 32'h0; wdata = 32'h0; be = 4'hF;
    req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;
    @(posedge clk); #1;

    // Reset state, and grant stays low while reset is held.
    chk("rst.rv", rv0, 0);
    chk("rst.rd", rd0, 0);
    chk("rst.err", err0, 0);
    req0 = 1'b1;
    #1 chk("rst.gnt_req", gnt0, 0);
    @(posedge clk); #1;
    res = 1'b0; req0 = 1'b0;
    @(posedge clk); #1;

    // Back-to-back store then load of the same word.
    req0 = 1'b1; we = 1'b1; addr = 32'h1004; wdata = 32'hDEAD_BEEF; be = 4'hF;
    #1 chk("b2b.st_gnt", gnt0, 1);
    chk("b2b.st_rv_pre", rv0, 0);
    @(posedge clk); #1;
    we = 1'b0; wdata = 32'h0;
    #1 chk("b2b.st_rv", rv0, 1);
    chk("b2b.st_rd", rd0, 0);
    chk("b2b.ld_gnt", gnt0, 1);
    @(posedge clk); #1;
    req0 = 1'b0;
    #1 chk("b2b.ld_rv", rv0, 1);
    chk("b2b.ld_rd", rd0, 32'hDEAD_BEEF);
    chk("b2b.ld_err", err0, 0);
    @(posedge clk); #1;
    chk("b2b.rv_end", rv0, 0);
    chk("b2b.rd_hold", rd0, 32'hDEAD_BEEF);

    // Byte enables.
    xact0("be.st_full", 1'b1, 32'h1008, 32'h1122_3344, 4'hF, 32'h0, 1'b0);
    xact0("be.st_0101", 1'b1, 32'h1008, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0);
    xact0("be.ld", 1'b0, 32'h1008, 32'h0, 4'hF, 32'h11BB_33DD, 1'b0);

    // Out of range accesses: granted, flagged, and no array word changes.
    xact0("oor.st_last", 1'b1, 32'h1FFC, 32'h55AA_55AA, 4'hF, 32'h0, 1'b0);
    xact0("oor.st_first", 1'b1, 32'h1000, 32'h1234_5678, 4'hF, 32'h0, 1'b0);
    xact0("oor.st_below", 1'b1, 32'h0FFC, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
    xact0("oor.st_past", 1'b1, 32'h2000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
    xact0("oor.ld_past", 1'b0, 32'h2000, 32'h0, 4'hF, 32'h0, 1'b1);
    xact0("oor.ld_last", 1'b0, 32'h1FFC, 32'h0, 4'hF, 32'h55AA_55AA, 1'b0);
    xact0("oor.ld_first", 1'b0, 32'h1000, 32'h0, 4'hF, 32'h1234_5678, 1'b0);
    xact0("unal.ld", 1'b0, 32'h1006, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0);

    // Long delays: store, then load with request held then dropped after grant.
    xact1("dly.st", 1'b1, 32'h1000, 32'h0BAD_F00D, 32'h0);
    xact1("dly.ld", 1'b0, 32'h1000, 32'h0, 32'h0BAD_F00D);

    // Reset during response latency of a load.
    req1 = 1'b1; we = 1'b0; addr = 32'h1000;
    for (int i = 0; i < 4; i++) begin
      #1 chk("rstl.gnt", gnt1, (i == 3) ? 1 : 0);
      @(posedge clk); #1;
    end
    res = 1'b1;
    #1 chk("rstl.gnt_req", gnt1, 0);
    chk("rstl.rv", rv1, 0);
    chk("rstl.rd", rd1, 0);
    chk("rstl.err", err1, 0);
    @(posedge clk); #1;
    res = 1'b0; req1 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1 chk("rstl.no_rv", rv1, 0);
      @(posedge clk); #1;
    end
    xact1("rstl.ld", 1'b0, 32'h1000, 32'h0, 32'h0BAD_F00D);

    // Abandoned request: one-cycle pulse gives no grant and no response.
    req2 = 1'b1; we = 1'b1; addr = 32'h1000; wdata = 32'hCAFE_F00D; be = 4'hF;
    #1 chk("abn.gnt0", gnt2, 0);
    @(posedge clk); #1;
    req2 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("abn.gnt", gnt2, 0);
      chk("abn.rv", rv2, 0);
      @(posedge clk); #1;
    end
    req2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("abn.regnt", gnt2, (i == 2) ? 1 : 0);
      @(posedge clk); #1;
    end
    req2 = 1'b0; we = 1'b0;
    #1 chk("abn.rv_new", rv2, 1);
    chk("abn.rd_new", rd2, 0);
    chk("abn.err_new", err2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
